i2c_cmd_sequencer: RTL and testbench
====================================

# i2c_cmd_sequencer

Command-queueing front end that sits directly upstream of the I2C byte driver. It buffers single-byte I2C transactions in a small FIFO and launches them one at a time on the driver's start/busy handshake. It captures read data when each transaction ends and returns one response per command, including a timeout flag when the driver hangs.

## Interface
- FIFO_DEPTH, default 4: command FIFO entries; must be a power of two, ≥2.
- TIMEOUT_CYCLES, default 65535: maximum clk cycles from the start of a launch to the driver releasing busy; range 1..65535.

- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous and active-low (0 = reset).
- cmd_valid  in  1  a command is offered.
- cmd_ready  out  1  sequencer can accept; equals !fifo_full.
- cmd_rw  in  1  0 = write, 1 = read.
- cmd_addr  in  7  slave address.
- cmd_data  in  8  write byte; ignored for reads.
- rsp_valid  out  1  a response is presented.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rw  out  1  rw of the completed command.
- rsp_data  out  8  read byte; 0 for writes and timeouts.
- rsp_timeout  out  1  transaction exceeded TIMEOUT_CYCLES.
- drv_start  out  1  to driver I2C_Start.
- drv_rw  out  1  to driver RW.
- drv_addr  out  7  to driver slave_addr.
- drv_wdata  out  8  to driver data_in.
- drv_busy  in  1  from driver busy.
- drv_rdata  in  8  from driver data_out.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  queued commands.
- idle  out  1  FIFO empty, FSM in IDLE, and no response pending.

## Operation
- FIFO push on cmd_valid && cmd_ready. Pop only when the FSM leaves IDLE. There is no bypass: a command pushed into an empty FIFO is seen by the FSM one cycle later.
- FSM states are IDLE, START, WAIT_DONE, RESP.
- IDLE: if the FIFO is not empty and drv_busy == 0:
  - pop the head;
  - register rw/addr/data into drv_rw/drv_addr/drv_wdata;
  - clear the timer;
  - go to START.
- START: drv_start = 1, held as a level. When drv_busy == 1, go to WAIT_DONE and drop drv_start.
- WAIT_DONE: on the first cycle with drv_busy == 0:
  - capture drv_rdata into rsp_data if rw = 1, else capture 0;
  - set rsp_timeout = 0;
  - go to RESP.
- Timer: counts in START and WAIT_DONE. When it reaches TIMEOUT_CYCLES:
  - set rsp_timeout = 1 and rsp_data = 0;
  - drop drv_start;
  - go to RESP.
  - Timeout has priority over a busy edge in the same cycle.
- RESP: rsp_valid = 1, with rsp_* held stable until rsp_valid && rsp_ready, then go to IDLE. No new launch happens while a response is pending.
- drv_rw/drv_addr/drv_wdata stay stable from entry into START until the next launch.
- Reset, asynchronous at any point including mid-transaction:
  - FSM goes to IDLE and the FIFO is flushed;
  - drv_start, rsp_valid, rsp_timeout, rsp_rw, rsp_data, drv_rw, drv_addr, drv_wdata and the timer all go to 0;
  - fifo_count = 0; idle = 1; cmd_ready = 1.
  - The driver is reset independently.

## Timing
- Command accepted on edge E0: the FIFO is non-empty after E0. The FSM pops on E1, and drv_start = 1 after E1.
- drv_start stays high until the edge that samples drv_busy = 1. With a driver that asserts busy 1 cycle after start, drv_start is high for exactly 2 cycles.
- Busy falls: rsp_valid = 1 after the next edge. rsp_valid drops on the edge where rsp_ready is sampled high.
- Back-to-back commands: the minimum gap between the drop of one drv_start and the rise of the next is 2 cycles (RESP handshake plus IDLE).
- Full FIFO: cmd_ready = 0. A pop in the same cycle frees space for the next cycle only; cmd_ready never depends combinationally on the pop.
- Empty FIFO with push and pop conditions in the same cycle: push only.
- fifo_count updates on every edge with a push, a pop, or both; both together leave it unchanged.
- A timeout after exactly TIMEOUT_CYCLES cycles in START+WAIT_DONE gives rsp_valid on the following cycle.

## Structure
- Package i2c_seq_pkg contains:
  - state enum: IDLE, START, WAIT_DONE, RESP;
  - packed struct i2c_cmd_t {rw, addr[6:0], data[7:0]};
  - packed struct i2c_rsp_t {rw, timeout, data[7:0]}.
- Sub-module i2c_cmd_fifo is a synchronous FIFO of i2c_cmd_t, parameterised by FIFO_DEPTH.
  - Read/write pointers carry one extra wrap bit; full/empty are derived from pointer compare; count is the pointer difference.
- The top level holds the FSM, the timer (16 bits), and the response registers.

## Test plan
- Single write (rw=0, addr=0x50, data=0xA5), driver model sets busy 1 cycle after start for 20 cycles → drv_addr=0x50, drv_wdata=0xA5, drv_rw=0. One response with rsp_rw=0, rsp_data=0x00, rsp_timeout=0.
- Single read of addr=0x3C, driver returns drv_rdata=0x7E as busy falls → rsp_rw=1, rsp_data=0x7E, exactly one rsp_valid handshake.
- Push 5 commands back-to-back with FIFO_DEPTH=4 while the driver is busy → cmd_ready drops after 4 accepts. Commands launch in order; fifo_count goes 4→3→…→0.
- Driver never asserts busy, TIMEOUT_CYCLES=100 → rsp_timeout=1 and rsp_data=0 after 100 cycles; drv_start then low; the next queued command launches.
- rsp_ready held low for 10 cycles → rsp_* stable, no new drv_start until the handshake.
- rst asserted low while in WAIT_DONE with 2 commands queued → drv_start=0, rsp_valid=0, fifo_count=0, idle=1 immediately; no launch after release until a new command is accepted.

Source files
------------

// File: rtl/i2c_seq_pkg.sv
// Shared types for the I2C command sequencer: FSM states, command and response records.
package i2c_seq_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        RESP      = 2'd3
    } state_e;

    typedef struct packed {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] data;
    } i2c_cmd_t;

    typedef struct packed {
        logic       rw;
        logic       timeout;
        logic [7:0] data;
    } i2c_rsp_t;

endpackage

// File: rtl/i2c_cmd_fifo.sv
// Purpose: synchronous command FIFO of i2c_cmd_t with wrap-bit pointers.
// Latency: a push is visible at the head one cycle later; no bypass.
// Backpressure: full/empty come from registered pointers only; push when full or pop when empty is ignored.
module i2c_cmd_fifo
    import i2c_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    localparam int AW = $clog2(FIFO_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_vld,
    input  i2c_cmd_t      push_dat,
    input  logic          pop_req,
    output i2c_cmd_t      head_dat,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    i2c_cmd_t    mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push, do_pop;

    // Same index with differing wrap bits means the writer has lapped the reader.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign count = wr_ptr_q - rd_ptr_q;

    assign do_push  = push_vld && !full;
    assign do_pop   = pop_req && !empty;
    assign head_dat = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Purpose: queues single-byte I2C commands and launches them one at a time on the driver start/busy handshake.
// Latency: accepted command drives drv_start two edges after acceptance; response one edge after busy falls or timeout.
// Backpressure: cmd_ready = !fifo_full; rsp_* held until rsp_ready, and no launch while a response is pending.
module i2c_cmd_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_rw,
    input  logic [6:0]                  cmd_addr,
    input  logic [7:0]                  cmd_data,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic                        rsp_rw,
    output logic [7:0]                  rsp_data,
    output logic                        rsp_timeout,
    output logic                        drv_start,
    output logic                        drv_rw,
    output logic [6:0]                  drv_addr,
    output logic [7:0]                  drv_wdata,
    input  logic                        drv_busy,
    input  logic [7:0]                  drv_rdata,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        idle
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e     state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic       drv_start_q, drv_start_d;
    i2c_cmd_t   drv_cmd_q, drv_cmd_d;
    i2c_rsp_t   rsp_q, rsp_d;
    logic       rsp_valid_q, rsp_valid_d;

    i2c_cmd_t   push_dat, head_dat;
    logic       fifo_full, fifo_empty, pop_req;

    assign push_dat = '{rw: cmd_rw, addr: cmd_addr, data: cmd_data};

    i2c_cmd_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (cmd_valid),
        .push_dat (push_dat),
        .pop_req  (pop_req),
        .head_dat (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        drv_start_d = drv_start_q;
        drv_cmd_d   = drv_cmd_q;
        rsp_d       = rsp_q;
        rsp_valid_d = rsp_valid_q;
        pop_req     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && !drv_busy) begin
                    pop_req     = 1'b1;
                    drv_cmd_d   = head_dat;
                    timer_d     = '0;
                    drv_start_d = 1'b1;
                    state_d     = START;
                end
            end
            START, WAIT_DONE: begin
                // Timer hitting its last count wins over any busy transition this cycle.
                if (timer_q == TO_LAST) begin
                    drv_start_d = 1'b0;
                    rsp_d       = '{rw: drv_cmd_q.rw, timeout: 1'b1, data: 8'h00};
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    timer_d = timer_q + 16'd1;
                    if (state_q == START && drv_busy) begin
                        drv_start_d = 1'b0;
                        state_d     = WAIT_DONE;
                    end else if (state_q == WAIT_DONE && !drv_busy) begin
                        rsp_d       = '{rw: drv_cmd_q.rw, timeout: 1'b0,
                                        data: drv_cmd_q.rw ? drv_rdata : 8'h00};
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            drv_start_q <= 1'b0;
            drv_cmd_q   <= '0;
            rsp_q       <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            drv_start_q <= drv_start_d;
            drv_cmd_q   <= drv_cmd_d;
            rsp_q       <= rsp_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign cmd_ready   = !fifo_full;
    assign drv_start   = drv_start_q;
    assign drv_rw      = drv_cmd_q.rw;
    assign drv_addr    = drv_cmd_q.addr;
    assign drv_wdata   = drv_cmd_q.data;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rw      = rsp_q.rw;
    assign rsp_timeout = rsp_q.timeout;
    assign rsp_data    = rsp_q.data;
    assign idle        = fifo_empty && (state_q == IDLE) && !rsp_valid_q;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed bench for i2c_cmd_sequencer: vector table of single transactions plus burst, stall and reset sequences.
module tb_i2c_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_rw = 1'b0;
    logic [6:0] cmd_addr = '0;
    logic [7:0] cmd_data = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic       rsp_rw;
    logic [7:0] rsp_data;
    logic       rsp_timeout;
    logic       drv_start;
    logic       drv_rw;
    logic [6:0] drv_addr;
    logic [7:0] drv_wdata;
    logic       drv_busy = 1'b0;
    logic [7:0] drv_rdata = 8'hEE;
    logic [2:0] fifo_count;
    logic       idle;

    int nerr = 0;
    int nchk = 0;

    // Driver model knobs
    int         busy_len = 20;
    logic       nobusy = 1'b0;
    logic       force_busy = 1'b0;
    logic [7:0] rd_val = 8'h00;

    i2c_cmd_sequencer #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rw(rsp_rw),
        .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
        .drv_start(drv_start), .drv_rw(drv_rw), .drv_addr(drv_addr),
        .drv_wdata(drv_wdata), .drv_busy(drv_busy), .drv_rdata(drv_rdata),
        .fifo_count(fifo_count), .idle(idle)
    );

    always #5 clk = ~clk;

    // Driver: raises busy one cycle after it sees start, holds it busy_len cycles, presents read data as it falls.
    logic st_s;
    logic act = 1'b0;
    int   cnt = 0;
    always @(posedge clk) begin
        st_s = drv_start;
        #1;
        if (!rst) begin
            act = 1'b0;
            cnt = 0;
        end else if (act) begin
            if (cnt <= 1) begin
                act = 1'b0;
                drv_rdata = rd_val;
            end else begin
                cnt = cnt - 1;
            end
        end else if (st_s && !nobusy) begin
            act = 1'b1;
            cnt = busy_len;
        end
        drv_busy = force_busy | act;
    end

    task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        nchk++;
        if (act_v !== exp_v) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act_v, exp_v, $time);
        end
    endtask

    task automatic push(input logic rw, input logic [6:0] a, input logic [7:0] d);
        int t;
        @(negedge clk);
        cmd_rw = rw; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
        t = 0;
        while (!cmd_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) chk("push_ready_timeout", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_start(input string name);
        for (int i = 0; i < 300 && !drv_start; i++) @(negedge clk);
        chk(name, 32'(drv_start), 32'd1);
    endtask

    task automatic wait_rsp(input string name);
        for (int i = 0; i < 300 && !rsp_valid; i++) @(negedge clk);
        chk(name, 32'(rsp_valid), 32'd1);
    endtask

    task automatic handshake(input string name);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk(name, 32'(rsp_valid), 32'd0);
    endtask

    typedef struct {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] data;
        logic       nb;
        logic [7:0] rdata;
        logic       e_rw;
        logic [7:0] e_data;
        logic       e_to;
        int         e_start_hi;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic stable;
        logic no_start;

        vecs[0] = '{1'b0, 7'h50, 8'hA5, 1'b0, 8'hC3, 1'b0, 8'h00, 1'b0, 2};
        vecs[1] = '{1'b1, 7'h3C, 8'h11, 1'b0, 8'h7E, 1'b1, 8'h7E, 1'b0, 2};
        vecs[2] = '{1'b1, 7'h11, 8'h22, 1'b1, 8'h5A, 1'b1, 8'h00, 1'b1, 100};
        vecs[3] = '{1'b0, 7'h7F, 8'hFF, 1'b0, 8'h66, 1'b0, 8'h00, 1'b0, 2};
        vecs[4] = '{1'b1, 7'h00, 8'h00, 1'b0, 8'h81, 1'b1, 8'h81, 1'b0, 2};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_drv_start", 32'(drv_start), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_drv_addr", 32'(drv_addr), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Table-driven single transactions
        for (int v = 0; v < 5; v++) begin
            busy_len = 20;
            nobusy   = vecs[v].nb;
            rd_val   = vecs[v].rdata;
            push(vecs[v].rw, vecs[v].addr, vecs[v].data);
            chk($sformatf("v%0d_count_after_push", v), 32'(fifo_count), 32'd1);
            chk($sformatf("v%0d_start_not_yet", v), 32'(drv_start), 32'd0);
            @(negedge clk);
            chk($sformatf("v%0d_start_after_pop", v), 32'(drv_start), 32'd1);
            chk($sformatf("v%0d_count_after_pop", v), 32'(fifo_count), 32'd0);
            chk($sformatf("v%0d_drv_rw", v), 32'(drv_rw), 32'(vecs[v].rw));
            chk($sformatf("v%0d_drv_addr", v), 32'(drv_addr), 32'(vecs[v].addr));
            chk($sformatf("v%0d_drv_wdata", v), 32'(drv_wdata), 32'(vecs[v].data));
            k = 0;
            while (drv_start && k < 300) begin
                @(negedge clk);
                k++;
            end
            chk($sformatf("v%0d_start_high_cycles", v), 32'(k), 32'(vecs[v].e_start_hi));
            if (vecs[v].nb) chk($sformatf("v%0d_timeout_timing", v), 32'(rsp_valid), 32'd1);
            wait_rsp($sformatf("v%0d_rsp_valid", v));
            chk($sformatf("v%0d_rsp_rw", v), 32'(rsp_rw), 32'(vecs[v].e_rw));
            chk($sformatf("v%0d_rsp_data", v), 32'(rsp_data), 32'(vecs[v].e_data));
            chk($sformatf("v%0d_rsp_timeout", v), 32'(rsp_timeout), 32'(vecs[v].e_to));
            chk($sformatf("v%0d_start_low_in_resp", v), 32'(drv_start), 32'd0);
            handshake($sformatf("v%0d_rsp_drop", v));
            @(negedge clk);
            chk($sformatf("v%0d_single_rsp", v), 32'(rsp_valid), 32'd0);
        end
        nobusy = 1'b0;

        // Fill the FIFO while the driver is busy; the fifth offer must be refused
        force_busy = 1'b1;
        busy_len = 3;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("burst_count_%0d", i), 32'(fifo_count), 32'(i < 4 ? i : 4));
            chk($sformatf("burst_ready_%0d", i), 32'(cmd_ready), 32'(i < 4));
            cmd_rw = 1'b0; cmd_addr = 7'(8'h40 + 8'(i)); cmd_data = 8'(i); cmd_valid = 1'b1;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk("burst_full_count", 32'(fifo_count), 32'd4);
        chk("burst_full_ready", 32'(cmd_ready), 32'd0);
        chk("burst_no_launch", 32'(drv_start), 32'd0);
        force_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_start($sformatf("burst_start_%0d", i));
            chk($sformatf("burst_addr_%0d", i), 32'(drv_addr), 32'(8'h40 + 8'(i)));
            chk($sformatf("burst_pop_count_%0d", i), 32'(fifo_count), 32'(3 - i));
            wait_rsp($sformatf("burst_rsp_%0d", i));
            handshake($sformatf("burst_rsp_drop_%0d", i));
        end
        repeat (3) @(negedge clk);
        chk("burst_idle", 32'(idle), 32'd1);

        // Stalled response: rsp_* stable, no new launch until the handshake
        busy_len = 5;
        rd_val = 8'h99;
        push(1'b1, 7'h22, 8'h00);
        push(1'b0, 7'h23, 8'h44);
        wait_rsp("stall_rsp_valid");
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!rsp_valid || rsp_data !== 8'h99 || rsp_rw !== 1'b1 || rsp_timeout !== 1'b0 || drv_start)
                stable = 1'b0;
            @(negedge clk);
        end
        chk("stall_stable", 32'(stable), 32'd1);
        chk("stall_queued", 32'(fifo_count), 32'd1);
        handshake("stall_rsp_drop");
        wait_start("stall_next_start");
        chk("stall_next_addr", 32'(drv_addr), 32'h23);
        wait_rsp("stall_next_rsp");
        chk("stall_next_data", 32'(rsp_data), 32'h00);
        handshake("stall_next_drop");

        // Reset while in WAIT_DONE with two commands queued
        busy_len = 30;
        push(1'b0, 7'h31, 8'h01);
        push(1'b0, 7'h32, 8'h02);
        push(1'b0, 7'h33, 8'h03);
        chk("mid_queued", 32'(fifo_count), 32'd2);
        chk("mid_in_wait", 32'(drv_start), 32'd0);
        chk("mid_busy", 32'(drv_busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_start", 32'(drv_start), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_count", 32'(fifo_count), 32'd0);
        chk("mid_rst_idle", 32'(idle), 32'd1);
        chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
        chk("mid_rst_addr", 32'(drv_addr), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        no_start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (drv_start) no_start = 1'b0;
        end
        chk("post_rst_no_launch", 32'(no_start), 32'd1);
        busy_len = 4;
        rd_val = 8'h3A;
        push(1'b1, 7'h55, 8'h00);
        wait_start("post_rst_start");
        chk("post_rst_addr", 32'(drv_addr), 32'h55);
        wait_rsp("post_rst_rsp");
        chk("post_rst_data", 32'(rsp_data), 32'h3A);
        handshake("post_rst_drop");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
